two_bit_scan_sequencer: RTL and testbench
=========================================

# two_bit_scan_sequencer

Upstream stage of the 2:4 decoder: generates the 2-bit position select that the decoder turns into one-hot outputs, e.g. for scanning a 4-digit multiplexed display or 4 LED columns. Holds each position for a programmable number of clocks, steps up or down, runs continuously or for one 4-position sweep, and flags every position change and sweep end. The `a`/`b` outputs connect directly to the decoder's `a` (LSB) and `b` (MSB) inputs.

## Interface
- `DIV`, default 4: clocks each position is held; legal range 1..255.
- `BLANK_CYC`, default 1: blanking clocks inserted between positions; legal range 1..15; used only when `SCAN_BLANK_EN` is defined.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begins a scan; honoured only in IDLE.
- `stop`  in  1  aborts a scan; honoured in any state.
- `mode`  in  1  0 = continuous, 1 = single sweep; latched at start.
- `dir`  in  1  0 = up (0,1,2,3), 1 = down (3,2,1,0); latched at start.
- `a`  out  1  select bit 0 (position LSB).
- `b`  out  1  select bit 1 (position MSB).
- `active`  out  1  high while the position on `{b,a}` is valid.
- `blank`  out  1  high during inter-position blanking; constant 0 without `SCAN_BLANK_EN`.
- `step`  out  1  one-clock pulse in the first cycle of each new position, including the first position.
- `done`  out  1  one-clock pulse when a single sweep completes.

## Operation
- The state register has three states: IDLE, RUN and BLANK. BLANK exists only with `SCAN_BLANK_EN`.
- Internal registers:
  - 2-bit position `pos`, with `{b,a} = pos`.
  - 8-bit hold counter `hcnt`.
  - 4-bit blank counter.
  - 2-bit sweep counter.
  - Latched copies of `mode` and `dir`.
- Reset (asynchronous, immediate): state IDLE, `pos` = 0, all counters 0. Outputs `a`=0, `b`=0, `active`=0, `blank`=0, `step`=0, `done`=0.
- IDLE with `start`=1 and `stop`=0:
  - Latch `mode` and `dir`.
  - Load `pos` = 0 if `dir`=0, else 3.
  - Clear `hcnt` and the sweep counter.
  - Go to RUN and assert `step` and `active`.
- RUN:
  - `hcnt` increments each clock.
  - When `hcnt` = DIV-1, the position ends and `hcnt` is cleared.
  - If the mode is single sweep and this is the 4th position: go to IDLE, pulse `done`, set `pos` = 0, drop `active`.
  - Otherwise, without the macro: `pos` advances (+1 up, -1 down, modulo 4, so 3→0 up and 0→3 down) and `step` pulses.
  - Otherwise, with the macro: go to BLANK instead of advancing.
- BLANK (macro only):
  - `active`=0, `blank`=1, and `pos` holds its old value.
  - After BLANK_CYC clocks, `pos` advances, the state returns to RUN, and `step` pulses.
- `stop`=1 in RUN or BLANK: next state IDLE, `pos` = 0, `active`=0, `blank`=0, no `done`.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the block stays IDLE.
- `start` in RUN or BLANK is ignored. `mode` and `dir` changes mid-scan have no effect.
- With DIV=1, the position changes every clock (no macro).

## Timing
- All outputs are registered.
- Latency from a `start` sample to `active`=1 / `step`=1 / first position on `{b,a}`: 1 clock.
- Without the macro, each position is held exactly DIV clocks. A continuous-scan period is 4·DIV clocks.
- With the macro, each position is active for DIV clocks followed by BLANK_CYC blank clocks. No blank follows the final position of a single sweep.
- `done` is asserted in the same cycle that `active` falls at sweep end. Total sweep without the macro is 4·DIV clocks of `active`.
- `stop` latency is 1 clock to `active`=0.
- `step` and `done` are never high in the same cycle.

## Configuration
- `SCAN_BLANK_EN` defined:
  - The BLANK state and the blank counter are compiled in.
  - The `blank` output is driven.
  - `active` is low during blanking, which suppresses decoder ghosting on multiplexed displays.
- `SCAN_BLANK_EN` undefined:
  - No BLANK state and no blank counter.
  - `blank` is tied to 0 and BLANK_CYC is ignored.
  - Positions change back-to-back.

## Test plan
- Reset, DIV=4, no macro; pulse `start` with `mode`=0, `dir`=0: `{b,a}` runs 0,1,2,3,0,… each held 4 clocks. `step` pulses every 4 clocks and `active` stays 1.
- `mode`=1, `dir`=1, DIV=2, no macro: `{b,a}` runs 3,2,1,0, each held 2 clocks. `done` pulses once 8 clocks after `active` rises, then `active`=0 and `{b,a}`=0.
- `stop` asserted on the 2nd clock of position 1: next cycle is IDLE with `active`=0 and `{b,a}`=0, and `done` never pulses. `start` and `stop` asserted together from IDLE: the block stays IDLE.
- `SCAN_BLANK_EN` defined, DIV=3, BLANK_CYC=2, continuous up: per position, 3 clocks `active`=1 followed by 2 clocks `blank`=1/`active`=0 with `pos` unchanged. `step` coincides with each new position.
- `rst` asserted asynchronously mid-RUN (between clock edges): all outputs go to 0 immediately. After release, nothing happens until `start`. DIV=1 continuous: `{b,a}` changes every clock and `step` is held high.

Source files
------------

// File: rtl/two_bit_scan_sequencer.sv
// ============================================================================
// two_bit_scan_sequencer
//
// Generates the 2-bit position select {b,a} that feeds a 2:4 decoder.
// Typical use is scanning a 4-digit multiplexed display or 4 LED columns.
// Each position is held for DIV clocks. The scan steps up (0,1,2,3) or down
// (3,2,1,0). It runs continuously or for one 4-position sweep. It flags every
// new position (step) and the end of a single sweep (done).
//
// Optional feature macro: SCAN_BLANK_EN
//   When defined, a BLANK state inserts BLANK_CYC clocks between positions.
//   During those clocks active=0 and blank=1, so the decoder outputs are
//   quiet while the select lines move (no ghosting). No blank follows the
//   last position of a single sweep.
//   When undefined, positions change back-to-back, blank is tied to 0 and
//   BLANK_CYC is only range-checked.
//
// Parameters
//   DIV        clocks each position is held (1..255)
//   BLANK_CYC  blanking clocks between positions (1..15, SCAN_BLANK_EN only)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a scan (honoured only in IDLE, and only if stop=0)
//   stop       abort a scan (honoured in any state)
//   mode       0 = continuous, 1 = single sweep (latched at start)
//   dir        0 = up, 1 = down (latched at start)
//   a, b       position select, {b,a} = position
//   active     position on {b,a} is valid
//   blank      inter-position blanking in progress
//   step       one-clock pulse in the first cycle of every new position
//   done       one-clock pulse when a single sweep completes
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = BLANK)
//
// Handshake: start/stop are level-sampled on every rising edge; there is no
// ready. A start seen in IDLE with stop low is accepted on that edge, and the
// first position appears one clock later. All outputs are registered.
// ============================================================================
module two_bit_scan_sequencer #(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       dir,
    output logic       a,
    output logic       b,
    output logic       active,
    output logic       blank,
    output logic       step,
    output logic       done,
    output logic [1:0] dbg_state
);

    // ------------------------------------------------------------------------
    // Parameter legality (elaboration time only)
    // ------------------------------------------------------------------------
    if (DIV < 1 || DIV > 255) begin : g_bad_div
        $error("two_bit_scan_sequencer: DIV must be in 1..255");
    end
    if (BLANK_CYC < 1 || BLANK_CYC > 15) begin : g_bad_blank
        $error("two_bit_scan_sequencer: BLANK_CYC must be in 1..15");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
`ifdef SCAN_BLANK_EN
    localparam logic [1:0] S_BLANK = 2'd2;
`endif

    // Terminal counts. The hold counter counts 0..DIV-1 inside one position.
    localparam logic [7:0] HOLD_LAST  = 8'(DIV - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] r_pos;
    logic [7:0] r_hcnt;
    logic [1:0] r_swcnt;     // positions completed in the current sweep
    logic       r_mode;
    logic       r_dir;
`ifdef SCAN_BLANK_EN
    logic [3:0] r_bcnt;
    logic       r_blank;
`endif
    logic       r_active;
    logic       r_step;
    logic       r_done;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_start_go;  // start accepted this edge
    logic       w_abort;     // stop seen while scanning
    logic       w_hold_end;  // last clock of the current position
    logic       w_sweep_end; // last clock of the 4th position of a single sweep
    logic       w_advance;   // pos moves to the next position this edge
    logic [1:0] w_pos_next;  // neighbour position in the latched direction
`ifdef SCAN_BLANK_EN
    logic       w_blank_end;
`endif

    logic       w_active_nxt;
    logic       w_step_nxt;
    logic       w_done_nxt;
`ifdef SCAN_BLANK_EN
    logic       w_blank_nxt;
`endif

    assign w_start_go  = (r_state == S_IDLE) && start && !stop;
    assign w_abort     = (r_state != S_IDLE) && stop;
    assign w_hold_end  = (r_state == S_RUN) && (r_hcnt == HOLD_LAST);
    assign w_sweep_end = w_hold_end && r_mode && (r_swcnt == 2'd3);
    // 2-bit arithmetic wraps naturally: 3->0 going up, 0->3 going down.
    assign w_pos_next  = r_dir ? (r_pos - 2'd1) : (r_pos + 2'd1);

`ifdef SCAN_BLANK_EN
    assign w_blank_end = (r_state == S_BLANK) && (r_bcnt == BLANK_LAST);
    // With blanking the move happens when the blank gap ends.
    assign w_advance   = w_blank_end && !stop;
`else
    // Without blanking the move happens directly at the end of the hold.
    assign w_advance   = w_hold_end && !w_sweep_end && !stop;
`endif

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_go) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop || w_sweep_end) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hold_end) begin
`ifdef SCAN_BLANK_EN
                    w_state_nxt = S_BLANK;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_blank_end) begin
                    w_state_nxt = S_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        w_active_nxt = (w_state_nxt == S_RUN);
        // step marks the first cycle of the first position and of every
        // later position; it never coincides with done because a sweep end
        // does not advance.
        w_step_nxt   = w_start_go || w_advance;
        w_done_nxt   = w_sweep_end && !stop;
`ifdef SCAN_BLANK_EN
        w_blank_nxt  = (w_state_nxt == S_BLANK);
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath: position, counters, latched controls
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= 2'd0;
            r_hcnt  <= 8'd0;
            r_swcnt <= 2'd0;
            r_mode  <= 1'b0;
            r_dir   <= 1'b0;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= 4'd0;
`endif
        end else if (w_start_go) begin
            r_mode  <= mode;
            r_dir   <= dir;
            r_pos   <= dir ? 2'd3 : 2'd0;
            r_hcnt  <= 8'd0;
            r_swcnt <= 2'd0;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= 4'd0;
`endif
        end else if (w_abort) begin
            r_pos   <= 2'd0;
            r_hcnt  <= 8'd0;
            r_swcnt <= 2'd0;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= 4'd0;
`endif
        end else if (r_state == S_RUN) begin
            if (w_hold_end) begin
                r_hcnt  <= 8'd0;
                r_swcnt <= r_swcnt + 2'd1;
                if (w_sweep_end) begin
                    r_pos <= 2'd0;
                end else begin
`ifdef SCAN_BLANK_EN
                    r_bcnt <= 4'd0;   // pos holds through the blank gap
`else
                    r_pos  <= w_pos_next;
`endif
                end
            end else begin
                r_hcnt <= r_hcnt + 8'd1;
            end
        end
`ifdef SCAN_BLANK_EN
        else if (r_state == S_BLANK) begin
            if (w_blank_end) begin
                r_bcnt <= 4'd0;
                r_pos  <= w_pos_next;
            end else begin
                r_bcnt <= r_bcnt + 4'd1;
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Registered status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SCAN_BLANK_EN
            r_blank  <= 1'b0;
`endif
        end else begin
            r_active <= w_active_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
`ifdef SCAN_BLANK_EN
            r_blank  <= w_blank_nxt;
`endif
        end
    end

    assign a         = r_pos[0];
    assign b         = r_pos[1];
    assign active    = r_active;
    assign step      = r_step;
    assign done      = r_done;
    assign dbg_state = r_state;
`ifdef SCAN_BLANK_EN
    assign blank     = r_blank;
`else
    assign blank     = 1'b0;
`endif

endmodule

// File: tb/tb_two_bit_scan_sequencer.sv
// ============================================================================
// tb_two_bit_scan_sequencer
//
// Three instances share clk/rst and have their own control inputs:
//   u0: DIV=4 (DIV=3 with SCAN_BLANK_EN), BLANK_CYC=2
//   u1: DIV=2, BLANK_CYC=1
//   u2: DIV=1, BLANK_CYC=1
// The expected output trace of a scan is computed from position/hold/blank
// arithmetic in exp_at(), pushed to exp_q when the stimulus is driven, and
// popped one entry per clock when the instance produces output.
// Observation word: {done, step, active, blank, b, a}.
// ============================================================================
module tb_two_bit_scan_sequencer;

    localparam int CLK_HALF = 5;

`ifdef SCAN_BLANK_EN
    localparam int DIV0 = 3;
    localparam int BC0  = 2;
    localparam int BC1  = 1;
    localparam int BC2  = 1;
`else
    localparam int DIV0 = 4;
    localparam int BC0  = 0;
    localparam int BC1  = 0;
    localparam int BC2  = 0;
`endif
    localparam int DIV1 = 2;
    localparam int DIV2 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #CLK_HALF clk = ~clk;

    logic [2:0] start_v, stop_v, mode_v, dir_v;
    logic [2:0] a_v, b_v, act_v, blk_v, stp_v, dn_v;
    logic [1:0] dbg_v [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q [$];

    two_bit_scan_sequencer #(.DIV(DIV0), .BLANK_CYC(2)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]),
        .mode(mode_v[0]), .dir(dir_v[0]), .a(a_v[0]), .b(b_v[0]),
        .active(act_v[0]), .blank(blk_v[0]), .step(stp_v[0]), .done(dn_v[0]),
        .dbg_state(dbg_v[0]));

    two_bit_scan_sequencer #(.DIV(DIV1), .BLANK_CYC(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]),
        .mode(mode_v[1]), .dir(dir_v[1]), .a(a_v[1]), .b(b_v[1]),
        .active(act_v[1]), .blank(blk_v[1]), .step(stp_v[1]), .done(dn_v[1]),
        .dbg_state(dbg_v[1]));

    two_bit_scan_sequencer #(.DIV(DIV2), .BLANK_CYC(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]),
        .mode(mode_v[2]), .dir(dir_v[2]), .a(a_v[2]), .b(b_v[2]),
        .active(act_v[2]), .blank(blk_v[2]), .step(stp_v[2]), .done(dn_v[2]),
        .dbg_state(dbg_v[2]));

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs(input int i);
        return {dn_v[i], stp_v[i], act_v[i], blk_v[i], b_v[i], a_v[i]};
    endfunction

    // Expected observation k clocks after the accepted start (k=0 is the
    // first cycle of the first position).
    function automatic logic [5:0] exp_at(input int k, input int div,
                                          input int bc, input bit md,
                                          input bit dr);
        int per, idx, w, kend;
        logic [1:0] p;
        per  = div + bc;
        idx  = k / per;
        w    = k % per;
        kend = 3 * per + div;
        if (md && k == kend) return 6'b100000;
        if (md && k > kend)  return 6'b000000;
        p = 2'(idx % 4);
        if (dr) p = 2'd3 - p;
        if (w < div) return {1'b0, (w == 0), 1'b1, 1'b0, p};
        return {1'b0, 1'b0, 1'b0, 1'b1, p};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] o;
        rst = 1'b1;
        start_v = '0; stop_v = '0; mode_v = '0; dir_v = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            n_tests++;
            if (o !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_out inst=%0d got=%b exp=000000", i, o);
            end
            n_tests++;
            if (dbg_v[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got=%0d exp=0", i, dbg_v[i]);
            end
        end
        rst = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            n_tests++;
            if (o !== 6'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle inst=%0d got=%b exp=000000", i, o);
            end
        end
    endtask

    task automatic test_continuous_up();
        int n;
        logic [5:0] e, o;
        n = 2 * 4 * (DIV0 + BC0) + 3;
        mode_v[0] = 1'b0; dir_v[0] = 1'b0; start_v[0] = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_at(k, DIV0, BC0, 1'b0, 1'b0));
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(0);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL cont_up k=%0d got=%b exp=%b", k, o, e);
            end
        end
        stop_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0;
        o = obs(0);
        n_tests++;
        if (o !== 6'b0 || dbg_v[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL cont_up_stop got=%b state=%0d exp=000000 state=0", o, dbg_v[0]);
        end
    endtask

    task automatic test_single_down();
        int n;
        logic [5:0] e, o;
        n = 3 * (DIV1 + BC1) + DIV1 + 4;
        mode_v[1] = 1'b1; dir_v[1] = 1'b1; start_v[1] = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_at(k, DIV1, BC1, 1'b1, 1'b1));
        tick();
        start_v[1] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(1);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_down k=%0d got=%b exp=%b", k, o, e);
            end
            // Mid-scan control changes and a repeated start must be ignored.
            if (k == 2) begin
                mode_v[1] = 1'b0; dir_v[1] = 1'b0; start_v[1] = 1'b1;
            end
            if (k == 4) start_v[1] = 1'b0;
        end
        n_tests++;
        if (dbg_v[1] !== 2'd0) begin
            n_fail++;
            $display("FAIL single_down_idle state=%0d exp=0", dbg_v[1]);
        end
    endtask

    task automatic test_back_to_back();
        int kend, n;
        logic [5:0] e, o;
        kend = 3 * (DIV1 + BC1) + DIV1;
        mode_v[1] = 1'b1; dir_v[1] = 1'b0; start_v[1] = 1'b1;
        for (int k = 0; k <= kend; k++) exp_q.push_back(exp_at(k, DIV1, BC1, 1'b1, 1'b0));
        for (int k = 0; k <= kend + 1; k++) exp_q.push_back(exp_at(k, DIV1, BC1, 1'b1, 1'b0));
        n = exp_q.size();
        tick();
        start_v[1] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(1);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, o, e);
            end
            // Restart in the done cycle: the block is already IDLE there.
            if (k == kend) start_v[1] = 1'b1;
            if (k == kend + 1) start_v[1] = 1'b0;
        end
    endtask

    task automatic test_stop();
        int ks, n;
        logic [5:0] e, o;
        ks = (DIV1 + BC1) + 1;  // second clock of position 1
        mode_v[1] = 1'b0; dir_v[1] = 1'b0; start_v[1] = 1'b1;
        for (int k = 0; k <= ks; k++) exp_q.push_back(exp_at(k, DIV1, BC1, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) exp_q.push_back(6'b000000);
        n = exp_q.size();
        tick();
        start_v[1] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(1);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stop_mid_run k=%0d got=%b exp=%b", k, o, e);
            end
            if (k == ks) stop_v[1] = 1'b1;
            if (k == ks + 1) stop_v[1] = 1'b0;
        end
        // start and stop together from IDLE: stop wins.
        start_v[1] = 1'b1; stop_v[1] = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(6'b000000);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                start_v[1] = 1'b0; stop_v[1] = 1'b0;
            end
            e = exp_q.pop_front();
            o = obs(1);
            n_tests++;
            if (o !== e || dbg_v[1] !== 2'd0) begin
                n_fail++;
                $display("FAIL start_stop_idle k=%0d got=%b state=%0d exp=%b state=0",
                         k, o, dbg_v[1], e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e, o;
        mode_v[0] = 1'b0; dir_v[0] = 1'b1; start_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_at(k, DIV0, BC0, 1'b0, 1'b1));
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(0);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_pre k=%0d got=%b exp=%b", k, o, e);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        o = obs(0);
        n_tests++;
        if (o !== 6'b0 || dbg_v[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%b state=%0d exp=000000 state=0", o, dbg_v[0]);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            o = obs(0);
            n_tests++;
            if (o !== 6'b0) begin
                n_fail++;
                $display("FAIL async_release_idle k=%0d got=%b exp=000000", k, o);
            end
        end
        mode_v[0] = 1'b0; dir_v[0] = 1'b0; start_v[0] = 1'b1;
        for (int k = 0; k < 2; k++) exp_q.push_back(exp_at(k, DIV0, BC0, 1'b0, 1'b0));
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(0);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_restart k=%0d got=%b exp=%b", k, o, e);
            end
        end
        stop_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0;
    endtask

    task automatic test_div1();
        int n;
        logic [5:0] e, o;
        n = 10 + 2 * BC2;
        mode_v[2] = 1'b0; dir_v[2] = 1'b0; start_v[2] = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_at(k, DIV2, BC2, 1'b0, 1'b0));
        tick();
        start_v[2] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            e = exp_q.pop_front();
            o = obs(2);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL div1 k=%0d got=%b exp=%b", k, o, e);
            end
        end
        stop_v[2] = 1'b1;
        tick();
        stop_v[2] = 1'b0;
        o = obs(2);
        n_tests++;
        if (o !== 6'b0) begin
            n_fail++;
            $display("FAIL div1_stop got=%b exp=000000", o);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_continuous_up();
        test_single_down();
        test_back_to_back();
        test_stop();
        test_async_reset();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the whole run is a few hundred clocks.
    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
